// File: rtl/dma_priority_resolver_if.sv
// Bus bundle between the DMA priority resolver and its surroundings.
// master: drives requests/registers/timing-FSM strobes; slave: the resolver.
interface dma_priority_resolver_if #(
  parameter int NCH = 4
);
  logic [NCH-1:0] DREQ;
  logic [NCH-1:0] maskReg;
  logic [NCH-1:0] requestReg;
  logic [7:0]     commandReg;
  logic           Program;
  logic           hlda;
  logic           validDACK;
  logic           serviceDone;
  logic [NCH-1:0] VALID_DREQ;
  logic [1:0]     grantCh;
  logic           grantValid;
  logic [NCH-1:0] DACK;

  modport master (
    output DREQ, maskReg, requestReg, commandReg, Program, hlda, validDACK, serviceDone,
    input  VALID_DREQ, grantCh, grantValid, DACK
  );

  modport slave (
    input  DREQ, maskReg, requestReg, commandReg, Program, hlda, validDACK, serviceDone,
    output VALID_DREQ, grantCh, grantValid, DACK
  );
endinterface

// File: rtl/dma_priority_resolver.sv
// 8237A-style DMA priority resolver: synchronises DREQ, applies mask /
// software requests / command bits, locks one channel for a whole service
// and drives DACK during the acknowledge window.
// Optional feature macro: DMA_ROTATE_PRIO_EN (rotating priority via commandReg[4]).
module dma_priority_resolver #(
  parameter int NCH      = 4,
  parameter int SYNC_STG = 2
) (
  input  logic                     CLK,
  input  logic                     RESET,
  dma_priority_resolver_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOCK = 2'd1, RELEASE = 2'd2} state_e;

  state_e                         state_q, state_d;
  logic [SYNC_STG-1:0][NCH-1:0]   sync_q, sync_d;
  logic [NCH-1:0]                 valid_dreq_q, valid_dreq_d;
  logic [1:0]                     grant_ch_q, grant_ch_d;
  logic                           grant_valid_q, grant_valid_d;
  logic                           dack_act_q, dack_act_d;
  logic [NCH-1:0]                 dack_q, dack_d;
`ifdef DMA_ROTATE_PRIO_EN
  logic [1:0]                     ptr_q, ptr_d;
  logic                           rot_q, rot_d;
`endif

  logic [NCH-1:0] dreq_n;
  logic [NCH-1:0] pending;
  logic [1:0]     start;
  logic [1:0]     idx;
  logic [1:0]     win_ch;
  logic           win_found;
  logic           lock_go;
  logic           abort;

  // Command bits this stage never looks at.
  logic unused_cmd;
`ifdef DMA_ROTATE_PRIO_EN
  assign unused_cmd = ^{bus.commandReg[5], bus.commandReg[3], bus.commandReg[1:0]};
`else
  assign unused_cmd = ^{bus.commandReg[5:3], bus.commandReg[1:0]};
`endif

  // Polarity normalisation, synchroniser chain, request qualification and winner search.
  always_comb begin
    dreq_n    = bus.commandReg[6] ? ~bus.DREQ : bus.DREQ;
    sync_d    = sync_q;
    sync_d[0] = dreq_n;
    for (int s = 1; s < SYNC_STG; s++) sync_d[s] = sync_q[s-1];
    pending   = (sync_q[SYNC_STG-1] & ~bus.maskReg) | bus.requestReg;
`ifdef DMA_ROTATE_PRIO_EN
    start     = bus.commandReg[4] ? ptr_q : 2'd0;
`else
    start     = 2'd0;
`endif
    win_found = 1'b0;
    win_ch    = 2'd0;
    idx       = 2'd0;
    for (int k = 0; k < NCH; k++) begin
      idx = start + 2'(k);
      if (!win_found && pending[idx]) begin
        win_found = 1'b1;
        win_ch    = idx;
      end
    end
    lock_go   = (pending != '0) && !bus.commandReg[2] && !bus.Program;
    // Requester went away before the bus was handed over.
    abort     = !bus.hlda && !pending[grant_ch_q];
  end

  // State register and all output/pointer flops.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= IDLE;
      sync_q        <= '0;
      valid_dreq_q  <= '0;
      grant_ch_q    <= 2'd0;
      grant_valid_q <= 1'b0;
      dack_act_q    <= 1'b0;
      dack_q        <= '1;
`ifdef DMA_ROTATE_PRIO_EN
      ptr_q         <= 2'd0;
      rot_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      valid_dreq_q  <= valid_dreq_d;
      grant_ch_q    <= grant_ch_d;
      grant_valid_q <= grant_valid_d;
      dack_act_q    <= dack_act_d;
      dack_q        <= dack_d;
`ifdef DMA_ROTATE_PRIO_EN
      ptr_q         <= ptr_d;
      rot_q         <= rot_d;
`endif
    end
  end

  // Next-state: serviceDone takes precedence over abort while locked.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (lock_go) state_d = LOCK;
      LOCK:    if (bus.serviceDone) state_d = RELEASE;
               else if (abort) state_d = IDLE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/next-register values: grant latch, release/abort clear, pointer rotation, DACK.
  always_comb begin
    valid_dreq_d  = valid_dreq_q;
    grant_ch_d    = grant_ch_q;
    grant_valid_d = grant_valid_q;
`ifdef DMA_ROTATE_PRIO_EN
    ptr_d         = ptr_q;
    rot_d         = rot_q;
`endif
    case (state_q)
      IDLE: begin
        if (lock_go) begin
          grant_ch_d           = win_ch;
          valid_dreq_d         = '0;
          valid_dreq_d[win_ch] = 1'b1;
          grant_valid_d        = 1'b1;
`ifdef DMA_ROTATE_PRIO_EN
          // Mode is frozen for the service so a mid-service write cannot affect the pointer.
          rot_d                = bus.commandReg[4];
`endif
        end
      end
      LOCK: begin
        if (bus.serviceDone) begin
          valid_dreq_d  = '0;
          grant_valid_d = 1'b0;
`ifdef DMA_ROTATE_PRIO_EN
          if (rot_q) ptr_d = grant_ch_q + 2'd1;
`endif
        end else if (abort) begin
          valid_dreq_d  = '0;
          grant_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    // DACK stays up from the first validDACK until the service ends or aborts.
    dack_act_d = (state_q == LOCK) && !bus.serviceDone && !abort &&
                 (dack_act_q || (bus.validDACK && grant_valid_q));
    dack_d     = {NCH{~bus.commandReg[7]}};
    if (dack_act_d) dack_d[grant_ch_q] = bus.commandReg[7];
  end

  assign bus.VALID_DREQ = valid_dreq_q;
  assign bus.grantCh    = grant_ch_q;
  assign bus.grantValid = grant_valid_q;
  assign bus.DACK       = dack_q;

endmodule
